car_datapath: RTL and testbench

Pixel-sweep datapath for the racing-game display pipeline. It executes the draw/erase commands issued by the race control FSM: it generates the `counterx`/`countery` sweep the FSM watches for completion, drives VGA-adapter pixel writes (`x`, `y`, `colour`, `plot_out`) and holds the car position register. It applies the straight, left and right moves. It sits between the control FSM and the 160x120 VGA adapter.

---
 rtl/car_datapath.sv | 199 +++++++++++++++++++
 tb/tb_car_datapath.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/car_datapath.sv
// Pixel-sweep datapath for the racing display: sweeps the background or the car box into the VGA adapter and holds the car position.
// Optional road pattern in the background colour is enabled by defining ROAD_STRIPES_EN.
module car_datapath #(
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned CAR_W      = 4,
    parameter int unsigned CAR_H      = 4,
    parameter int unsigned START_X    = 78,
    parameter int unsigned START_Y    = 100,
    parameter int unsigned STEP       = 1,
    parameter logic [2:0]  BG_COLOUR  = 3'b010,
    parameter logic [2:0]  CAR_COLOUR = 3'b100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw_bg,
    input  logic       draw_car,
    input  logic       erase,
    input  logic       move_straight,
    input  logic       move_left,
    input  logic       move_right,
    output logic [7:0] counterx,
    output logic [7:0] countery,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot_out,
    output logic       sweep_done,
    output logic [7:0] car_x,
    output logic [6:0] car_y
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;
    localparam int unsigned XMAX = SCREEN_W - CAR_W;
    localparam int unsigned YWRAP = SCREEN_H - CAR_H;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_BG    = 2'd1,
        MODE_ERASE = 2'd2,
        MODE_CAR   = 2'd3
    } mode_t;

`ifdef ROAD_STRIPES_EN
    localparam int unsigned ROAD_LO  = 40;
    localparam int unsigned ROAD_HI  = 120;
    localparam int unsigned STRIPE_A = 79;
    localparam int unsigned STRIPE_B = 80;

    // Dark road between the verges, with a dashed white centre line (8 rows on, 8 off).
    function automatic logic [CW-1:0] bg_colour_at(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic [CW-1:0] c;
        c = BG_COLOUR;
        if (px >= XW'(ROAD_LO) && px < XW'(ROAD_HI))
            c = 3'b000;
        if ((px == XW'(STRIPE_A) || px == XW'(STRIPE_B)) && !py[3])
            c = 3'b111;
        return c;
    endfunction
`endif

    mode_t          mode;
    mode_t          prev_mode;
    logic [XW-1:0]  org_x;
    logic [YW-1:0]  org_y;

    logic [XW-1:0]  sweep_w;
    logic [XW-1:0]  sweep_h;
    logic [XW-1:0]  counterx_n;
    logic [XW-1:0]  countery_n;
    logic [XW-1:0]  org_x_n;
    logic [YW-1:0]  org_y_n;
    logic           emit;
    logic [XW-1:0]  px;
    logic [YW-1:0]  py;
    logic [CW-1:0]  bg_col;
    logic [CW-1:0]  pix_colour;
    logic [XW-1:0]  car_x_n;
    logic [YW-1:0]  car_y_n;
    logic [XW:0]    right_sum;

    // Mode select and sweep sequencing.
    always_comb begin
        mode       = MODE_NONE;
        sweep_w    = XW'(CAR_W);
        sweep_h    = XW'(CAR_H);
        counterx_n = counterx;
        countery_n = countery;
        org_x_n    = org_x;
        org_y_n    = org_y;
        emit       = 1'b0;

        if (draw_bg)
            mode = MODE_BG;
        else if (erase)
            mode = MODE_ERASE;
        else if (draw_car)
            mode = MODE_CAR;

        if (mode == MODE_BG) begin
            sweep_w = XW'(SCREEN_W);
            sweep_h = XW'(SCREEN_H);
        end

        if (mode == MODE_NONE || mode != prev_mode) begin
            // Origin is captured here so the box cannot move under an active sweep.
            counterx_n = '0;
            countery_n = '0;
            if (mode == MODE_BG) begin
                org_x_n = '0;
                org_y_n = '0;
            end else begin
                org_x_n = car_x;
                org_y_n = car_y;
            end
        end else if (counterx < sweep_w) begin
            emit = 1'b1;
            if (counterx == sweep_w - XW'(1)) begin
                if (countery < sweep_h - XW'(1)) begin
                    counterx_n = '0;
                    countery_n = countery + XW'(1);
                end else begin
                    counterx_n = sweep_w;
                end
            end else begin
                counterx_n = counterx + XW'(1);
            end
        end

        px = org_x + counterx;
        py = org_y + YW'(countery);
`ifdef ROAD_STRIPES_EN
        bg_col = bg_colour_at(px, py);
`else
        bg_col = BG_COLOUR;
`endif
        pix_colour = (mode == MODE_CAR) ? CAR_COLOUR : bg_col;
    end

    assign sweep_done = (mode != MODE_NONE) && (counterx == sweep_w);

    // Car movement, only while no sweep is requested.
    always_comb begin
        car_x_n   = car_x;
        car_y_n   = car_y;
        right_sum = (XW+1)'(car_x) + (XW+1)'(STEP);
        if (mode == MODE_NONE) begin
            if (move_straight) begin
                if (car_y >= YW'(STEP))
                    car_y_n = car_y - YW'(STEP);
                else
                    car_y_n = YW'(YWRAP);
            end else if (move_left) begin
                if (car_x >= XW'(STEP))
                    car_x_n = car_x - XW'(STEP);
                else
                    car_x_n = '0;
            end else if (move_right) begin
                if (right_sum > (XW+1)'(XMAX))
                    car_x_n = XW'(XMAX);
                else
                    car_x_n = XW'(right_sum);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_mode <= MODE_NONE;
            counterx  <= '0;
            countery  <= '0;
            org_x     <= '0;
            org_y     <= '0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot_out  <= 1'b0;
            car_x     <= XW'(START_X);
            car_y     <= YW'(START_Y);
        end else begin
            prev_mode <= mode;
            counterx  <= counterx_n;
            countery  <= countery_n;
            org_x     <= org_x_n;
            org_y     <= org_y_n;
            plot_out  <= emit;
            if (emit) begin
                x      <= px;
                y      <= py;
                colour <= pix_colour;
            end
            car_x     <= car_x_n;
            car_y     <= car_y_n;
        end
    end

endmodule

// File: tb/tb_car_datapath.sv
// Scoreboard bench for car_datapath: expected pixels are queued by the stimulus and consumed by a plot monitor.
module tb_car_datapath;

`ifdef ROAD_STRIPES_EN
    localparam bit STRIPES = 1'b1;
`else
    localparam bit STRIPES = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] col;
    } pix_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       draw_bg = 1'b0, draw_car = 1'b0, erase = 1'b0;
    logic       move_straight = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic [7:0] counterx, countery, x, car_x;
    logic [6:0] y, car_y;
    logic [2:0] colour;
    logic       plot_out, sweep_done;

    int   checks = 0;
    int   errors = 0;
    int   plots  = 0;
    pix_t exp_q[$];

    car_datapath dut (
        .clock(clock), .reset(reset),
        .draw_bg(draw_bg), .draw_car(draw_car), .erase(erase),
        .move_straight(move_straight), .move_left(move_left), .move_right(move_right),
        .counterx(counterx), .countery(countery),
        .x(x), .y(y), .colour(colour), .plot_out(plot_out),
        .sweep_done(sweep_done), .car_x(car_x), .car_y(car_y)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] bg_at(input int px, input int py);
        if (STRIPES && (px == 79 || px == 80) && ((py / 8) % 2 == 0))
            return 3'b111;
        if (STRIPES && px >= 40 && px < 120)
            return 3'b000;
        return 3'b010;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_bg(input int n);
        pix_t p;
        for (int k = 0; k < n; k++) begin
            p.px  = 8'(k % 160);
            p.py  = 7'(k / 160);
            p.col = bg_at(k % 160, k / 160);
            exp_q.push_back(p);
        end
    endtask

    task automatic push_box(input int ox, input int oy, input bit car);
        pix_t p;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                p.px  = 8'(ox + i);
                p.py  = 7'(oy + j);
                p.col = car ? 3'b100 : bg_at(ox + i, oy + j);
                exp_q.push_back(p);
            end
    endtask

    task automatic pulse(input bit s, input bit l, input bit r, input int n);
        for (int k = 0; k < n; k++) begin
            move_straight = s;
            move_left     = l;
            move_right    = r;
            tick();
            move_straight = 1'b0;
            move_left     = 1'b0;
            move_right    = 1'b0;
        end
    endtask

    // Plot monitor: every write strobe must match the next queued pixel.
    always @(negedge clock) begin
        if (plot_out) begin
            pix_t e;
            plots++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL plot_unexpected: got (%0d,%0d,%0d) expected no plot", x, y, colour);
            end else begin
                e = exp_q.pop_front();
                if (x != e.px || y != e.py || colour != e.col) begin
                    errors++;
                    $display("FAIL plot: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             x, y, colour, e.px, e.py, e.col);
                end
            end
        end
    end

    initial begin
        tick(2);
        check("rst_counterx", int'(counterx), 0);
        check("rst_countery", int'(countery), 0);
        check("rst_plot", int'(plot_out), 0);
        check("rst_xyc", int'({x, y, colour}), 0);
        check("rst_done", int'(sweep_done), 0);
        check("rst_car_x", int'(car_x), 78);
        check("rst_car_y", int'(car_y), 100);
        reset = 1'b0;
        tick();

        // Full background sweep.
        plots = 0;
        push_bg(19200);
        draw_bg = 1'b1;
        tick(19201);
        check("bg_counterx_end", int'(counterx), 160);
        check("bg_countery_end", int'(countery), 119);
        check("bg_done", int'(sweep_done), 1);
        tick();
        check("bg_hold", int'(counterx), 160);
        check("bg_plot_fall", int'(plot_out), 0);
        check("bg_plot_count", plots, 19200);
        check("bg_queue_empty", exp_q.size(), 0);
        draw_bg = 1'b0;
        tick();
        check("none_clears", int'(counterx), 0);
        check("none_done", int'(sweep_done), 0);

        // Car draw, with a move pulse ignored mid-sweep.
        plots = 0;
        push_box(78, 100, 1'b1);
        draw_car = 1'b1;
        tick(5);
        pulse(1'b0, 1'b0, 1'b1, 1);
        check("move_ignored", int'(car_x), 78);
        tick(11);
        check("car_counterx_end", int'(counterx), 4);
        check("car_done", int'(sweep_done), 1);
        tick(2);
        check("car_hold", int'(counterx), 4);
        check("car_plot_count", plots, 16);
        check("car_queue_empty", exp_q.size(), 0);
        draw_car = 1'b0;
        tick();

        // Moves: priority, clamps and wrap.
        pulse(1'b1, 1'b1, 1'b0, 1);
        check("prio_y", int'(car_y), 99);
        check("prio_x", int'(car_x), 78);
        pulse(1'b0, 1'b1, 1'b0, 78);
        check("left_to_0", int'(car_x), 0);
        pulse(1'b0, 1'b1, 1'b0, 1);
        check("left_clamp", int'(car_x), 0);
        pulse(1'b0, 1'b0, 1'b1, 156);
        check("right_to_156", int'(car_x), 156);
        pulse(1'b0, 1'b0, 1'b1, 1);
        check("right_clamp", int'(car_x), 156);
        pulse(1'b1, 1'b0, 1'b0, 99);
        check("up_to_0", int'(car_y), 0);
        pulse(1'b1, 1'b0, 1'b0, 1);
        check("up_wrap", int'(car_y), 116);
        pulse(1'b0, 1'b1, 1'b0, 78);
        pulse(1'b1, 1'b0, 1'b0, 16);
        check("restore_x", int'(car_x), 78);
        check("restore_y", int'(car_y), 100);

        // Background interrupted by erase after 50 pixels.
        plots = 0;
        push_bg(50);
        draw_bg = 1'b1;
        tick(51);
        draw_bg = 1'b0;
        erase   = 1'b1;
        push_box(78, 100, 1'b0);
        tick();
        check("switch_clear", int'(counterx), 0);
        check("switch_idle", int'(plot_out), 0);
        tick(16);
        check("erase_counterx_end", int'(counterx), 4);
        check("erase_done", int'(sweep_done), 1);
        tick();
        check("switch_plot_count", plots, 66);
        check("erase_queue_empty", exp_q.size(), 0);
        erase = 1'b0;
        tick();

        // Reset in the middle of a background sweep.
        pulse(1'b0, 1'b0, 1'b1, 1);
        check("pre_reset_x", int'(car_x), 79);
        push_bg(10);
        draw_bg = 1'b1;
        tick(11);
        reset = 1'b1;
        tick();
        check("rst_mid_plot", int'(plot_out), 0);
        check("rst_mid_counterx", int'(counterx), 0);
        check("rst_mid_countery", int'(countery), 0);
        check("rst_mid_car_x", int'(car_x), 78);
        check("rst_mid_car_y", int'(car_y), 100);
        reset   = 1'b0;
        draw_bg = 1'b0;
        tick(3);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
